// File: rtl/hilotof_pkg.sv
// Shared HiLoTOF protocol definitions: ASCII constants, hex helpers and encoder states.
package hilotof_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_R  = 8'h52;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEX,
    ST_TERM,
    ST_RST
  } tx_state_e;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  // Returns {valid, nibble}; only uppercase A-F count as hex digits.
  function automatic logic [4:0] ascii_to_hex(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'b0_0000;
  endfunction

endpackage

// File: rtl/hilotof_line_parser.sv
// Receive side: accumulates ASCII hex digits per line and reports words or malformed lines.
module hilotof_line_parser
  import hilotof_pkg::*;
(
  input  logic        clock,
  input  logic        sys_reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] resp_word,
  output logic        resp_valid,
  output logic        resp_error
);

  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic [4:0]  dec;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    word_d  = word_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    dec     = ascii_to_hex(rx_data);
    if (rx_valid) begin
      if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
        // An empty line (e.g. the LF after CR) is silently ignored.
        if (bad_q || (cnt_q != 4'd0 && cnt_q != 4'd8)) begin
          error_d = 1'b1;
        end else if (cnt_q == 4'd8) begin
          valid_d = 1'b1;
          word_d  = acc_q;
        end
        acc_d = '0;
        cnt_d = '0;
        bad_d = 1'b0;
      end else if (dec[4]) begin
        acc_d = {acc_q[27:0], dec[3:0]};
        if (cnt_q != 4'd9) cnt_d = cnt_q + 4'd1;
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign resp_word  = word_q;
  assign resp_valid = valid_q;
  assign resp_error = error_q;

endmodule

// File: rtl/hilotof_host.sv
// Host end of the HiLoTOF UART link: encodes commands to ASCII lines and parses result lines.
module hilotof_host
  import hilotof_pkg::*;
(
  input  logic        clock,
  input  logic        sys_reset_n,
  input  logic [31:0] cmd_word,
  input  logic        cmd_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] resp_word,
  output logic        resp_valid,
  output logic        resp_error
);

  tx_state_e   state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  idx_q, idx_d;

  always_ff @(posedge clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  // The latched word shifts left per sent digit, so the current digit is always word_q[31:28].
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_reset) begin
            state_d = ST_RST;
          end else begin
            state_d = ST_HEX;
            word_d  = cmd_word;
            idx_d   = '0;
          end
        end
      end
      ST_HEX: begin
        if (tx_ready) begin
          word_d = {word_q[27:0], 4'h0};
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_TERM;
        end
      end
      ST_TERM: if (tx_ready) state_d = ST_IDLE;
      ST_RST:  if (tx_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    tx_valid  = 1'b1;
    tx_data   = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        tx_valid  = 1'b0;
      end
      ST_HEX:  tx_data = hex_to_ascii(word_q[31:28]);
      ST_TERM: tx_data = ASCII_LF;
      ST_RST:  tx_data = ASCII_R;
      default: tx_valid = 1'b0;
    endcase
  end

  hilotof_line_parser u_parser (
    .clock       (clock),
    .sys_reset_n (sys_reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .resp_word   (resp_word),
    .resp_valid  (resp_valid),
    .resp_error  (resp_error)
  );

endmodule
